// File: rtl/rf_wport_arbiter.sv
// Arbitrates the single register-file write port between pipeline writeback and the
// multi-cycle mul/div unit, and tracks outstanding MC destinations for hazard detection.
module rf_wport_arbiter #(
    parameter int MAX_WAIT = 4,
    parameter int WAIT_W   = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        wb_valid,
    input  logic [4:0]  wb_wR,
    input  logic [31:0] wb_wD,
    output logic        wb_stall,
    input  logic        mc_issue,
    input  logic [4:0]  mc_rd,
    input  logic        mc_valid,
    input  logic [4:0]  mc_wR,
    input  logic [31:0] mc_wD,
    output logic        mc_ready,
    input  logic [4:0]  rR1,
    input  logic [4:0]  rR2,
    output logic        rd_hazard,
    output logic        rf_we,
    output logic [4:0]  rf_wR,
    output logic [31:0] rf_wD
);

    typedef enum logic [0:0] {
        ARB_NORMAL = 1'b0,
        ARB_STARVE = 1'b1
    } arb_state_t;

    localparam logic [WAIT_W-1:0] WAIT_MAX  = WAIT_W'(MAX_WAIT);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MAX_WAIT - 1);

    arb_state_t        state_r;
    arb_state_t        state_s;
    logic [31:0]       busy_r;
    logic [31:0]       busy_s;
    logic [WAIT_W-1:0] wait_cnt_r;
    logic [WAIT_W-1:0] wait_cnt_s;

    logic        waw_s;
    logic        wb_grant_s;
    logic        mc_ready_s;
    logic        wb_stall_s;
    logic        mc_deny_s;
    logic        mc_xfer_s;
    logic        rf_we_s;
    logic [4:0]  rf_wR_s;
    logic [31:0] rf_wD_s;
    logic        rd_hazard_s;

    // Grant decision: WB has priority unless it would overwrite a pending MC target
    // or MC has been starved long enough to force its way in.
    always_comb begin
        waw_s      = busy_r[wb_wR] & (wb_wR != 5'd0);
        wb_grant_s = 1'b0;
        wb_stall_s = 1'b0;
        mc_ready_s = 1'b0;
        case (state_r)
            ARB_STARVE: begin
                wb_grant_s = 1'b0;
                wb_stall_s = wb_valid;
                mc_ready_s = mc_valid;
            end
            default: begin
                wb_grant_s = wb_valid & ~waw_s;
                wb_stall_s = wb_valid & waw_s;
                mc_ready_s = mc_valid & ~wb_grant_s;
            end
        endcase
        if (!rst_n) begin
            wb_grant_s = 1'b0;
            wb_stall_s = 1'b0;
            mc_ready_s = 1'b0;
        end else begin
            wb_grant_s = wb_grant_s;
        end
    end

    assign mc_xfer_s = mc_valid & mc_ready_s;
    assign mc_deny_s = mc_valid & ~mc_ready_s;

    // Write-port mux; a granted write to r0 still handshakes but never enables the RF.
    always_comb begin
        rf_we_s = 1'b0;
        rf_wR_s = 5'd0;
        rf_wD_s = 32'd0;
        if (mc_xfer_s) begin
            rf_we_s = (mc_wR != 5'd0);
            rf_wR_s = mc_wR;
            rf_wD_s = mc_wD;
        end else if (wb_grant_s) begin
            rf_we_s = (wb_wR != 5'd0);
            rf_wR_s = wb_wR;
            rf_wD_s = wb_wD;
        end else begin
            rf_we_s = 1'b0;
        end
    end

    // Hazard looks only at registered busy, so it stays up through the commit cycle.
    always_comb begin
        rd_hazard_s = ((rR1 != 5'd0) & busy_r[rR1]) | ((rR2 != 5'd0) & busy_r[rR2]);
        if (!rst_n) begin
            rd_hazard_s = 1'b0;
        end else begin
            rd_hazard_s = rd_hazard_s;
        end
    end

    // Next-state for starvation tracking and the busy scoreboard.
    always_comb begin
        state_s    = state_r;
        wait_cnt_s = wait_cnt_r;
        busy_s     = busy_r;

        if (mc_deny_s) begin
            wait_cnt_s = (wait_cnt_r == WAIT_MAX) ? WAIT_MAX : (wait_cnt_r + {{(WAIT_W-1){1'b0}}, 1'b1});
        end else begin
            wait_cnt_s = {WAIT_W{1'b0}};
        end

        case (state_r)
            ARB_NORMAL: begin
                if (mc_deny_s && (wait_cnt_r == WAIT_LAST)) begin
                    state_s = ARB_STARVE;
                end else begin
                    state_s = ARB_NORMAL;
                end
            end
            ARB_STARVE: begin
                if (mc_xfer_s || !mc_valid) begin
                    state_s = ARB_NORMAL;
                end else begin
                    state_s = ARB_STARVE;
                end
            end
            default: begin
                state_s = ARB_NORMAL;
            end
        endcase

        // Clear before set so a same-cycle reissue to the committing register stays busy.
        if (mc_xfer_s) begin
            busy_s[mc_wR] = 1'b0;
        end else begin
            busy_s = busy_s;
        end
        if (mc_issue && (mc_rd != 5'd0)) begin
            busy_s[mc_rd] = 1'b1;
        end else begin
            busy_s = busy_s;
        end
        busy_s[0] = 1'b0;
    end

    // State registers; reset discards every outstanding MC destination.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= ARB_NORMAL;
            wait_cnt_r <= {WAIT_W{1'b0}};
            busy_r     <= 32'd0;
        end else begin
            state_r    <= state_s;
            wait_cnt_r <= wait_cnt_s;
            busy_r     <= busy_s;
        end
    end

    assign wb_stall  = wb_stall_s;
    assign mc_ready  = mc_ready_s;
    assign rf_we     = rf_we_s;
    assign rf_wR     = rf_wR_s;
    assign rf_wD     = rf_wD_s;
    assign rd_hazard = rd_hazard_s;

endmodule
